// File: rtl/imm_encoder.sv
// RV32I immediate encoder: packs opcode, register fields, funct3 and a signed
// immediate into an instruction word, range-checks the immediate, and queues results.
module imm_encoder #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       fmt,
   input  logic [6:0]       opcode,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] enc_count,
   output logic [ERR_W-1:0] err_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Handshake: a word moves on a rising edge when valid && ready on that side;
   // ready never depends combinationally on the same side's valid.

   logic [31:0] packed_inst;
   logic        range_ok;
   logic [31:0] word_inst;
   logic        word_err;

   logic        hi11_ok, hi12_ok, hi20_ok;

   assign hi11_ok = (&imm[31:11]) | ~(|imm[31:11]);
   assign hi12_ok = (&imm[31:12]) | ~(|imm[31:12]);
   assign hi20_ok = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      packed_inst = '0;
      range_ok    = 1'b0;
      case (fmt)
         3'b000: begin
            packed_inst = {imm[11:0], rs1, funct3, rd, opcode};
            range_ok    = hi11_ok;
         end
         3'b001: begin
            packed_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            range_ok    = hi11_ok;
         end
         3'b010: begin
            packed_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            range_ok    = hi12_ok & ~imm[0];
         end
         3'b011: begin
            packed_inst = {imm[31:12], rd, opcode};
            range_ok    = ~(|imm[11:0]);
         end
         3'b100: begin
            packed_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            range_ok    = hi20_ok & ~imm[0];
         end
         default: begin
            packed_inst = '0;
            range_ok    = 1'b0;
         end
      endcase
   end

   // Rejected immediates still produce a harmless NOP so downstream sees one word per request.
   assign word_inst = range_ok ? packed_inst : NOP_INST;
   assign word_err  = ~range_ok;

   logic [32:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push, pop;

   assign in_ready  = rst_n & (count_q < FULL_CNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Gated by out_valid so an empty queue (including right after reset) shows zeros.
   assign out_inst = out_valid ? mem_q[rd_ptr_q][31:0] : '0;
   assign out_err  = out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {word_err, word_inst};
      end
   end

   logic [CNT_W-1:0] enc_q, enc_d;
   logic [ERR_W-1:0] errc_q, errc_d;

   always_comb begin
      enc_d  = enc_q;
      errc_d = errc_q;
      if (clr_cnt) begin
         enc_d  = '0;
         errc_d = '0;
      end else if (pop) begin
         if (enc_q != '1) enc_d = enc_q + 1'b1;
         if (out_err && (errc_q != '1)) errc_d = errc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         enc_q    <= '0;
         errc_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         enc_q    <= enc_d;
         errc_q   <= errc_d;
      end
   end

   assign enc_count = enc_q;
   assign err_count = errc_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: hand-computed encodings, backpressure,
// counter saturation/clear and asynchronous reset.
module tb_imm_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic        clr_cnt;
   logic [15:0] enc_count;
   logic [7:0]  err_count;

   int n_cmp;
   int n_mis;
   int exp_enc;
   int exp_errc;

   imm_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fmt       (fmt),
      .opcode    (opcode),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .funct3    (funct3),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_err   (out_err),
      .clr_cnt   (clr_cnt),
      .enc_count (enc_count),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                             input logic [31:0] im);
      fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
   endtask

   // Starts and ends at a falling edge; queue must be empty on entry.
   task automatic send_word(input string tag, input logic [2:0] f, input logic [6:0] op,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [2:0] f3, input logic [31:0] im,
                            input logic [31:0] exp_inst, input logic exp_err);
      out_ready = 1'b1;
      set_fields(f, op, d, s1, s2, f3, im);
      in_valid = 1'b1;
      #1 check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".inst"}, out_inst, exp_inst);
      check({tag, ".err"}, {31'd0, out_err}, {31'd0, exp_err});
      @(negedge clk);
      exp_enc++;
      if (exp_err) exp_errc++;
      check({tag, ".enc_count"}, {16'd0, enc_count}, 32'(exp_enc));
      check({tag, ".err_count"}, {24'd0, err_count}, 32'(exp_errc));
   endtask

   initial begin
      n_cmp = 0; n_mis = 0; exp_enc = 0; exp_errc = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
      set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);

      repeat (2) @(negedge clk);
      #1;
      check("rst.in_ready", {31'd0, in_ready}, 32'd0);
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.out_inst", out_inst, 32'd0);
      check("rst.out_err", {31'd0, out_err}, 32'd0);
      check("rst.enc_count", {16'd0, enc_count}, 32'd0);
      check("rst.err_count", {24'd0, err_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rel.in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);

      // Unused fields are driven with junk so copying them would show up.
      send_word("enc_i",    3'b000, 7'h13, 5'd5,  5'd6, 5'd31, 3'd0, 32'hFFFF_FFFF, 32'hFFF3_0293, 1'b0);
      send_word("enc_s",    3'b001, 7'h23, 5'd31, 5'd2, 5'd3,  3'd2, 32'hFFFF_FFFC, 32'hFE31_2E23, 1'b0);
      send_word("enc_i_rg", 3'b000, 7'h13, 5'd5,  5'd6, 5'd0,  3'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
      send_word("enc_b",    3'b010, 7'h63, 5'd31, 5'd1, 5'd2,  3'd0, 32'd8,         32'h0020_8463, 1'b0);
      send_word("enc_b_odd",3'b010, 7'h63, 5'd0,  5'd1, 5'd2,  3'd0, 32'd7,         32'h0000_0013, 1'b1);
      send_word("enc_j",    3'b100, 7'h6F, 5'd1,  5'd7, 5'd9,  3'd5, 32'h0000_0800, 32'h0010_00EF, 1'b0);
      send_word("enc_u",    3'b011, 7'h37, 5'd10, 5'd7, 5'd9,  3'd5, 32'h1234_5000, 32'h1234_5537, 1'b0);
      send_word("enc_u_lo", 3'b011, 7'h37, 5'd10, 5'd0, 5'd0,  3'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
      send_word("enc_f111", 3'b111, 7'h37, 5'd10, 5'd0, 5'd0,  3'd0, 32'h1234_5000, 32'h0000_0013, 1'b1);
      send_word("enc_j_rg", 3'b100, 7'h6F, 5'd1,  5'd0, 5'd0,  3'd0, 32'h0010_0000, 32'h0000_0013, 1'b1);

      // Backpressure: three back-to-back words into a two-entry queue.
      out_ready = 1'b0;
      set_fields(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      set_fields(3'b000, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
      #1 check("bp.rdy_second", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      set_fields(3'b000, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3);
      #1;
      check("bp.full_rdy", {31'd0, in_ready}, 32'd0);
      check("bp.head_a", out_inst, 32'h0010_0093);
      @(negedge clk);
      #1;
      check("bp.still_full", {31'd0, in_ready}, 32'd0);
      check("bp.hold_a", out_inst, 32'h0010_0093);
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp.head_b", out_inst, 32'h0020_0113);
      check("bp.rdy_after_pop", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("bp.head_c", out_inst, 32'h0030_0193);
      @(negedge clk);
      exp_enc += 3;
      #1;
      check("bp.empty", {31'd0, out_valid}, 32'd0);
      check("bp.enc_count", {16'd0, enc_count}, 32'(exp_enc));

      // Clear, then saturate the error counter with a continuous error stream.
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      exp_enc = 0; exp_errc = 0;
      #1 check("clr.enc_count", {16'd0, enc_count}, 32'd0);
      set_fields(3'b111, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      repeat (255) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      exp_enc = 255; exp_errc = 255;
      #1;
      check("sat.err_count", {24'd0, err_count}, 32'd255);
      check("sat.enc_count", {16'd0, enc_count}, 32'd255);
      @(negedge clk);
      exp_errc = 254;  // send_word adds one; the counter must hold at 255
      send_word("sat_hold", 3'b111, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h0000_0013, 1'b1);

      // Clear with a same-cycle pop.
      set_fields(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      clr_cnt  = 1'b1;
      #1 check("clrpop.valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      clr_cnt = 1'b0;
      exp_enc = 0; exp_errc = 0;
      #1;
      check("clrpop.enc_count", {16'd0, enc_count}, 32'd0);
      check("clrpop.err_count", {24'd0, err_count}, 32'd0);
      check("clrpop.empty", {31'd0, out_valid}, 32'd0);
      @(negedge clk);

      // Asynchronous reset with two words queued and nonzero counters.
      send_word("pre_rst", 3'b111, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h0000_0013, 1'b1);
      out_ready = 1'b0;
      set_fields(3'b000, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd4);
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("arst.queued", {31'd0, out_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst.out_valid", {31'd0, out_valid}, 32'd0);
      check("arst.out_inst", out_inst, 32'd0);
      check("arst.enc_count", {16'd0, enc_count}, 32'd0);
      check("arst.err_count", {24'd0, err_count}, 32'd0);
      check("arst.in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_enc = 0; exp_errc = 0;
      @(negedge clk);
      send_word("post_rst", 3'b000, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF3_0293, 1'b0);
      #1 check("post_rst.empty", {31'd0, out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
